// File: rtl/dcache_arb_pkg.sv
// Shared types for the data-cache request arbiter: request/response payloads,
// arbiter FSM states and the port-index width helper.
package dcache_arb_pkg;

    localparam int unsigned ArbAddrWidth = 64;
    localparam int unsigned ArbDataWidth = 64;
    localparam int unsigned ArbUserWidth = 64;

    typedef struct packed {
        logic [ArbAddrWidth-1:0]   addr;
        logic                      we;
        logic [ArbDataWidth/8-1:0] be;
        logic [ArbDataWidth-1:0]   wdata;
        logic [ArbUserWidth-1:0]   wuser;
    } dcache_req_t;

    typedef struct packed {
        logic [ArbDataWidth-1:0] rdata;
        logic [ArbUserWidth-1:0] ruser;
    } dcache_rsp_t;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_arb_id_fifo.sv
// In-order FIFO of granted port indices; the head names the owner of the next response.
module dcache_arb_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_en, pop_en;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (push_en && !pop_en) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop_en && !push_en) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one OBI-style dcache port between NrPorts requesters,
// with a lock on the pending request and in-order response routing.
module dcache_req_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int unsigned NrPorts        = 3,
    parameter int unsigned AddrWidth      = ArbAddrWidth,
    parameter int unsigned DataWidth      = ArbDataWidth,
    parameter bit          DataUserEn     = 1'b0,
    parameter int unsigned DataUserWidth  = ArbUserWidth,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NrPorts-1:0]               req_i,
    input  logic [NrPorts*AddrWidth-1:0]     addr_i,
    input  logic [NrPorts-1:0]               we_i,
    input  logic [NrPorts*DataWidth/8-1:0]   be_i,
    input  logic [NrPorts*DataWidth-1:0]     wdata_i,
    input  logic [NrPorts*DataUserWidth-1:0] wuser_i,
    output logic [NrPorts-1:0]               gnt_o,
    output logic [NrPorts-1:0]               rvalid_o,
    output logic [DataWidth-1:0]             rdata_o,
    output logic [DataUserWidth-1:0]         ruser_o,
    output logic                             req_o,
    output logic [AddrWidth-1:0]             addr_o,
    output logic                             we_o,
    output logic [DataWidth/8-1:0]           be_o,
    output logic [DataWidth-1:0]             wdata_o,
    output logic [DataUserWidth-1:0]         wuser_o,
    input  logic                             gnt_i,
    input  logic                             rvalid_i,
    input  logic [DataWidth-1:0]             rdata_i,
    input  logic [DataUserWidth-1:0]         ruser_i,
    output logic                             err_o
);

    localparam int unsigned PortW = idx_width(NrPorts);
    localparam int unsigned BeW   = DataWidth / 8;

    arb_state_e       state_q, state_d;
    logic [PortW-1:0] rr_q, rr_d, lock_q, lock_d;
    logic [PortW-1:0] arb_idx, cand, sel, head;
    logic             any_req, fifo_full, fifo_empty, push, pop, err_q;
    dcache_req_t      port_req [NrPorts];
    dcache_req_t      sel_req;
    dcache_rsp_t      rsp;

    always_comb begin
        for (int p = 0; p < NrPorts; p++) begin
            port_req[p].addr  = addr_i[p*AddrWidth +: AddrWidth];
            port_req[p].we    = we_i[p];
            port_req[p].be    = be_i[p*BeW +: BeW];
            port_req[p].wdata = wdata_i[p*DataWidth +: DataWidth];
            port_req[p].wuser = DataUserEn ? wuser_i[p*DataUserWidth +: DataUserWidth] : '0;
        end
    end

    // First requesting port at or after the round-robin pointer.
    always_comb begin
        arb_idx = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int i = 0; i < NrPorts; i++) begin
            cand = PortW'((int'(rr_q) + i) % int'(NrPorts));
            if (!any_req && req_i[cand]) begin
                any_req = 1'b1;
                arb_idx = cand;
            end
        end
    end

    assign sel     = (state_q == StLocked) ? lock_q : arb_idx;
    assign sel_req = port_req[sel];
    // Fullness uses the registered count, so a same-cycle pop never frees a slot.
    assign req_o   = (state_q == StLocked) || (any_req && !fifo_full);

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_o) begin
                    if (gnt_i) begin
                        push = 1'b1;
                    end else begin
                        lock_d  = sel;
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (gnt_i) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (push) begin
            rr_d = (sel == PortW'(NrPorts - 1)) ? '0 : sel + PortW'(1);
        end
    end

    assign pop = rvalid_i && !fifo_empty;

    always_comb begin
        rsp.rdata = rdata_i;
        rsp.ruser = DataUserEn ? ruser_i : '0;
        for (int p = 0; p < NrPorts; p++) begin
            gnt_o[p]    = push && (sel == PortW'(p));
            rvalid_o[p] = pop && (head == PortW'(p));
        end
        rdata_o = pop ? rsp.rdata : '0;
        ruser_o = pop ? rsp.ruser : '0;
        addr_o  = req_o ? sel_req.addr : '0;
        we_o    = req_o ? sel_req.we : 1'b0;
        be_o    = req_o ? sel_req.be : '0;
        wdata_o = req_o ? sel_req.wdata : '0;
        wuser_o = req_o ? sel_req.wuser : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rr_q    <= '0;
            lock_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            err_q   <= err_q | (rvalid_i && fifo_empty);
        end
    end

    assign err_o = err_q;

    dcache_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (PortW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Scoreboard bench for dcache_req_arbiter; a second instance with DataUserEn=1
// shares all inputs to compare sideband behaviour.
module tb_dcache_req_arbiter;

    localparam int NrP = 3;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int UW  = 64;
    localparam int BW  = DW / 8;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NrP-1:0]    req_i, we_i;
    logic [NrP*AW-1:0] addr_i;
    logic [NrP*BW-1:0] be_i;
    logic [NrP*DW-1:0] wdata_i;
    logic [NrP*UW-1:0] wuser_i;
    logic              gnt_i, rvalid_i;
    logic [DW-1:0]     rdata_i;
    logic [UW-1:0]     ruser_i;

    logic [NrP-1:0] gnt_o, rvalid_o, u_gnt_o, u_rvalid_o;
    logic [DW-1:0]  rdata_o, wdata_o, u_rdata_o, u_wdata_o;
    logic [UW-1:0]  ruser_o, wuser_o, u_ruser_o, u_wuser_o;
    logic [AW-1:0]  addr_o, u_addr_o;
    logic [BW-1:0]  be_o, u_be_o;
    logic           req_o, we_o, err_o, u_req_o, u_we_o, u_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_gnt[$];
    int exp_rsp[$];

    always #5 clk = ~clk;

    dcache_req_arbiter #(
        .NrPorts(NrP), .AddrWidth(AW), .DataWidth(DW), .DataUserEn(1'b0),
        .DataUserWidth(UW), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .wuser_i(wuser_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .ruser_o(ruser_o), .req_o(req_o),
        .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o), .wuser_o(wuser_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .ruser_i(ruser_i),
        .err_o(err_o)
    );

    dcache_req_arbiter #(
        .NrPorts(NrP), .AddrWidth(AW), .DataWidth(DW), .DataUserEn(1'b1),
        .DataUserWidth(UW), .MaxOutstanding(4)
    ) dut_u (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .wuser_i(wuser_i), .gnt_o(u_gnt_o),
        .rvalid_o(u_rvalid_o), .rdata_o(u_rdata_o), .ruser_o(u_ruser_o), .req_o(u_req_o),
        .addr_o(u_addr_o), .we_o(u_we_o), .be_o(u_be_o), .wdata_o(u_wdata_o),
        .wuser_o(u_wuser_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .ruser_i(ruser_i), .err_o(u_err_o)
    );

    function automatic logic [AW-1:0] port_addr(int p);
        return 64'h1000_0000 + 64'(p) * 64'h100;
    endfunction

    function automatic logic [DW-1:0] port_wdata(int p);
        return 64'hAAAA_0000 + 64'(p);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pops an expected grant / response whenever the DUT presents one.
    task automatic sb_sample(string tag);
        int e;
        if (gnt_o !== '0) begin
            n_checks++;
            if (exp_gnt.size() == 0) begin
                n_fail++;
                $display("FAIL %s unexpected grant: got gnt_o=%b, required none", tag, gnt_o);
            end else begin
                e = exp_gnt.pop_front();
                exp_rsp.push_back(e);
                if (gnt_o !== (3'b001 << e) || addr_o !== port_addr(e)) begin
                    n_fail++;
                    $display("FAIL %s grant: got gnt_o=%b addr_o=%h, required port %0d addr %h",
                             tag, gnt_o, addr_o, e, port_addr(e));
                end
            end
        end
        if (rvalid_o !== '0) begin
            n_checks++;
            if (exp_rsp.size() == 0) begin
                n_fail++;
                $display("FAIL %s unexpected rvalid: got rvalid_o=%b, required none",
                         tag, rvalid_o);
            end else begin
                e = exp_rsp.pop_front();
                if (rvalid_o !== (3'b001 << e)) begin
                    n_fail++;
                    $display("FAIL %s rvalid: got rvalid_o=%b, required port %0d",
                             tag, rvalid_o, e);
                end
            end
        end
    endtask

    task automatic check_drained(string tag);
        n_checks++;
        if (exp_gnt.size() != 0 || exp_rsp.size() != 0) begin
            n_fail++;
            $display("FAIL %s drain: got %0d grants / %0d responses pending, required 0 / 0",
                     tag, exp_gnt.size(), exp_rsp.size());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = '0; we_i = '0; gnt_i = 1'b0; rvalid_i = 1'b0;
        rdata_i = '0; ruser_i = '0; wuser_i = '0; be_i = '1;
        for (int p = 0; p < NrP; p++) begin
            addr_i[p*AW +: AW]  = port_addr(p);
            wdata_i[p*DW +: DW] = port_wdata(p);
        end
        #1;
        n_checks++;
        if ({req_o, gnt_o, rvalid_o, err_o, addr_o, rdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got req=%b gnt=%b rvalid=%b err=%b, required all 0",
                     req_o, gnt_o, rvalid_o, err_o);
        end
        cyc();
        rst_ni = 1'b1;
        cyc();
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 6; k++) exp_gnt.push_back(k % NrP);
        req_i = 3'b111; gnt_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) req_i = '0;
            rvalid_i = (i > 0);
            #1;
            sb_sample("rr");
            n_checks++;
            if (exp_rsp.size() > 1) begin
                n_fail++;
                $display("FAIL rr outstanding: got %0d, required <= 1", exp_rsp.size());
            end
            cyc();
        end
        rvalid_i = 1'b0; gnt_i = 1'b0;
        check_drained("rr");
    endtask

    task automatic test_lock();
        exp_gnt.push_back(1);
        exp_gnt.push_back(0);
        req_i = 3'b010; gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) req_i = 3'b011;
            #1;
            n_checks++;
            if (req_o !== 1'b1 || addr_o !== port_addr(1) || gnt_o !== '0) begin
                n_fail++;
                $display("FAIL lock hold: got req=%b addr=%h gnt=%b, required 1 %h 000",
                         req_o, addr_o, gnt_o, port_addr(1));
            end
            cyc();
        end
        gnt_i = 1'b1;
        #1; sb_sample("lock"); cyc();
        req_i = 3'b001; rvalid_i = 1'b1;
        #1; sb_sample("lock"); cyc();
        req_i = '0;
        #1; sb_sample("lock"); cyc();
        rvalid_i = 1'b0; gnt_i = 1'b0;
        check_drained("lock");
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) exp_gnt.push_back(2);
        req_i = 3'b100; gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            sb_sample("full");
            n_checks++;
            if (req_o !== (i < 4) || (i >= 4 && gnt_o !== '0)) begin
                n_fail++;
                $display("FAIL full req %0d: got req_o=%b gnt_o=%b, required req_o=%b",
                         i, req_o, gnt_o, (i < 4));
            end
            cyc();
        end
        rvalid_i = 1'b1;
        #1;
        sb_sample("full");
        n_checks++;
        if (req_o !== 1'b0 || gnt_o !== '0) begin
            n_fail++;
            $display("FAIL full same-cycle pop: got req_o=%b gnt_o=%b, required 0 000",
                     req_o, gnt_o);
        end
        cyc();
        exp_gnt.push_back(2);
        rvalid_i = 1'b0;
        #1;
        n_checks++;
        if (req_o !== 1'b1 || gnt_o !== 3'b100) begin
            n_fail++;
            $display("FAIL full regrant: got req_o=%b gnt_o=%b, required 1 100", req_o, gnt_o);
        end
        sb_sample("full");
        cyc();
        req_i = '0; rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; sb_sample("full"); cyc();
        end
        rvalid_i = 1'b0; gnt_i = 1'b0;
        check_drained("full");
    endtask

    task automatic test_data();
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        req_i = 3'b001; we_i = 3'b000; gnt_i = 1'b1;
        #1;
        sb_sample("data");
        n_checks++;
        if (we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL data read we: got %b, required 0", we_o);
        end
        cyc();
        req_i = 3'b010; we_i = 3'b010;
        #1;
        sb_sample("data");
        n_checks++;
        if (we_o !== 1'b1 || wdata_o !== port_wdata(1)) begin
            n_fail++;
            $display("FAIL data write: got we=%b wdata=%h, required 1 %h",
                     we_o, wdata_o, port_wdata(1));
        end
        cyc();
        req_i = '0; we_i = '0; gnt_i = 1'b0; rvalid_i = 1'b1;
        rdata_i = 64'hDEAD_BEEF_0000_0001;
        #1;
        sb_sample("data");
        n_checks++;
        if (rdata_o !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL data rdata: got %h, required %h", rdata_o, 64'hDEAD_BEEF_0000_0001);
        end
        cyc();
        rdata_i = 64'h0000_0000_0000_0123;
        #1; sb_sample("data"); cyc();
        rvalid_i = 1'b0; rdata_i = '0;
        check_drained("data");
    endtask

    task automatic test_user();
        exp_gnt.push_back(2);
        wuser_i = '1; req_i = 3'b100; gnt_i = 1'b1;
        #1;
        sb_sample("user");
        n_checks++;
        if (wuser_o !== '0 || u_wuser_o !== {UW{1'b1}}) begin
            n_fail++;
            $display("FAIL user wuser: got %h / %h, required 0 / all ones", wuser_o, u_wuser_o);
        end
        cyc();
        req_i = '0; gnt_i = 1'b0; rvalid_i = 1'b1; ruser_i = 64'h5;
        #1;
        sb_sample("user");
        n_checks++;
        if (ruser_o !== '0 || u_ruser_o !== 64'h5 || u_rvalid_o !== 3'b100) begin
            n_fail++;
            $display("FAIL user ruser: got %h / %h (u_rvalid %b), required 0 / 5 (100)",
                     ruser_o, u_ruser_o, u_rvalid_o);
        end
        cyc();
        rvalid_i = 1'b0; ruser_i = '0; wuser_i = '0;
        check_drained("user");
    endtask

    task automatic test_err();
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err before: got %b, required 0", err_o);
        end
        rvalid_i = 1'b1;
        #1;
        n_checks++;
        if (rvalid_o !== '0) begin
            n_fail++;
            $display("FAIL err rvalid: got %b, required 000", rvalid_o);
        end
        cyc();
        rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (err_o !== 1'b1) begin
                n_fail++;
                $display("FAIL err sticky %0d: got %b, required 1", i, err_o);
            end
            cyc();
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err reset: got %b, required 0", err_o);
        end
        cyc();
        rst_ni = 1'b1;
        cyc();
        // A grant discarded by reset must make its late response an error.
        req_i = 3'b001; gnt_i = 1'b1;
        cyc();
        req_i = '0; gnt_i = 1'b0; rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        cyc();
        rvalid_i = 1'b1;
        #1;
        n_checks++;
        if (rvalid_o !== '0) begin
            n_fail++;
            $display("FAIL err after reset rvalid: got %b, required 000", rvalid_o);
        end
        cyc();
        rvalid_i = 1'b0;
        #1;
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err after reset: got %b, required 1", err_o);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_data();
        test_user();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
- Shares one OBI-style data-cache request port between NrPorts requesters: load unit, store unit and AMO unit.
- Arbitration is round-robin with a stable lock on the pending request.
- Tracks up to MaxOutstanding in-flight transactions and routes each in-order response back to its originator.
- Sits between the load/store unit and the dcache; user sideband follows the DataUser configuration (XLEN 64).

Parameters:
- NrPorts, 3, number of requesters (2..8)
- AddrWidth, 64, request address width
- DataWidth, 64, data width (= XLEN)
- DataUserEn, 0, 1 = propagate user sideband; 0 = drive user outputs to zero
- DataUserWidth, 64, user sideband width
- MaxOutstanding, 4, in-flight transaction limit (power of two, ≥2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NrPorts  per-port request
- addr_i  in  NrPorts*AddrWidth  per-port address
- we_i  in  NrPorts  per-port write enable
- be_i  in  NrPorts*DataWidth/8  per-port byte enables
- wdata_i  in  NrPorts*DataWidth  per-port write data
- wuser_i  in  NrPorts*DataUserWidth  per-port write user
- gnt_o  out  NrPorts  per-port grant
- rvalid_o  out  NrPorts  per-port response valid
- rdata_o  out  DataWidth  response data, shared by all ports
- ruser_o  out  DataUserWidth  response user, shared
- req_o  out  1  downstream request
- addr_o  out  AddrWidth  downstream address
- we_o  out  1  downstream write enable
- be_o  out  DataWidth/8  downstream byte enables
- wdata_o  out  DataWidth  downstream write data
- wuser_o  out  DataUserWidth  downstream write user
- gnt_i  in  1  downstream grant
- rvalid_i  in  1  downstream response valid
- rdata_i  in  DataWidth  downstream response data
- ruser_i  in  DataUserWidth  downstream response user
- err_o  out  1  sticky protocol error: response with nothing outstanding

Behaviour:
- Reset: all outputs 0; rr pointer 0; lock cleared; ID FIFO empty; err_o 0.
- FSM, two states:
  - IDLE:
    - If FIFO not full and any req_i, select the first requesting port at or after the rr pointer.
    - Drive req_o and the selected port's payload combinationally (0-cycle latency).
    - gnt_i=1 in the same cycle: gnt_o[sel]=1, push sel, rr pointer := sel+1 mod NrPorts, stay IDLE.
    - gnt_i=0: latch sel, go LOCKED.
  - LOCKED:
    - req_o stays asserted with payload from the latched port; no re-arbitration even if a higher-priority port raises req.
    - On gnt_i: gnt_o[latched]=1, push, advance pointer, go IDLE.
- Requesters hold req and payload stable until gnt_o; arbiter behaviour is undefined if a locked requester drops req.
- FIFO full (MaxOutstanding in flight): req_o=0, no gnt_o, stays IDLE.
  - Full is evaluated on registered count only: a same-cycle pop does not free a slot for a same-cycle push.
  - Full is never reached while LOCKED, because arbitration only starts when not full.
- Every granted transaction (read or write) receives exactly one rvalid_i, in grant order, at least 1 cycle after grant.
- On rvalid_i with FIFO non-empty:
  - rvalid_o[head]=1, same cycle; rdata_o = rdata_i; ruser_o = DataUserEn ? ruser_i : 0.
  - Pop head.
- Same-cycle grant and response: push and pop both occur; count unchanged.
- rvalid_i with FIFO empty: no rvalid_o, err_o set and held until reset.
- DataUserEn=0: wuser_o=0, ruser_o=0 regardless of inputs.
- Count and pointers wrap modulo MaxOutstanding; count width is clog2(MaxOutstanding)+1.
- Reset mid-operation discards outstanding IDs; responses arriving after reset set err_o.

Decomposition:
- dcache_arb_pkg holds:
  - dcache_req_t: addr, we, be, wdata, wuser.
  - dcache_rsp_t: rdata, ruser.
  - Arbiter FSM state enum.
  - Port-index width function.
- One sub-module, dcache_arb_id_fifo:
  - Depth MaxOutstanding, element width clog2(NrPorts).
  - Push/pop with full, empty and head outputs; same reset.

Test Plan:
- Ports 0,1,2 request continuously with gnt_i=1, rvalid_i one cycle later → grants 0,1,2,0,1,2; rvalid_o follows the same order; never more than 1 outstanding.
- Port 1 requests with gnt_i=0 for 3 cycles; port 0 raises req in cycle 2 → addr_o stays at port 1's address; gnt_o[1] when gnt_i rises; port 0 is granted next.
- gnt_i=1, rvalid_i held 0, 6 back-to-back requests on port 2 → 4 grants, then req_o=0; one rvalid_i → next grant one cycle later, not in the same cycle.
- Grant port 0 (read, rdata_i=64'hDEAD_BEEF_0000_0001) then port 1 (write); two responses → rvalid_o[0] with that data, then rvalid_o[1].
- rvalid_i pulse after reset with nothing outstanding → no rvalid_o; err_o=1 until rst_ni low.
- DataUserEn=0, wuser_i all ones, ruser_i=64'h5 → wuser_o=0 and ruser_o=0; DataUserEn=1 → values pass through unchanged.
